square_wave_ctrl: RTL and testbench

SQUARE_WAVE_CTRL -- requirements
Module: square_wave_ctrl

---
 rtl/wavegen_pkg.sv | 30 +++
 rtl/wavegen_nco.sv | 45 ++++
 rtl/square_wave_ctrl.sv | 111 +++++++++++
 tb/tb_square_wave_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wavegen_pkg.sv
// Shared types and constants for the square-wave sample generator.
// Config fields are sized at the default widths and resized at each use.
package wavegen_pkg;

  localparam int ACC_W_DEFAULT  = 24;
  localparam int ADDR_W_DEFAULT = 10;
  localparam int DIV_W_DEFAULT  = 16;
  localparam logic [3:0] SEL_MAX = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  typedef logic [ACC_W_DEFAULT-1:0] ftw_t;
  typedef logic [DIV_W_DEFAULT-1:0] div_t;

  typedef struct packed {
    ftw_t       ftw;
    logic [3:0] sel;
    div_t       div;
  } cfg_t;

  // Out-of-range duty selects fall back to 0 rather than indexing past the LUT.
  function automatic logic [3:0] clamp_sel(input logic [3:0] sel);
    return (sel > SEL_MAX) ? 4'd0 : sel;
  endfunction

endpackage

// File: rtl/wavegen_nco.sv
// Sample-rate divider plus phase accumulator; exposes the next address and carry
// so the controller can decide whether to commit the step.
module wavegen_nco
  import wavegen_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DIV_W  = DIV_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              load,
  input  logic              clear,
  input  logic [ACC_W-1:0]  ftw,
  input  logic [DIV_W-1:0]  div,
  output logic              tick,
  output logic [ADDR_W-1:0] addr_next,
  output logic              carry
);

  logic [DIV_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  // >= rather than == so a smaller divider applied mid-count cannot strand the counter.
  assign tick      = run && (cnt >= div);
  assign sum       = {1'b0, acc} + {1'b0, ftw};
  assign addr_next = sum[ACC_W-1 -: ADDR_W];
  assign carry     = sum[ACC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (clear) begin
      cnt <= '0;
      acc <= '0;
    end else begin
      if (run) cnt <= tick ? '0 : cnt + DIV_W'(1);
      if (load) acc <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/square_wave_ctrl.sv
// Run/stop control, shadowed configuration and the valid/ready sample port
// feeding the square-wave LUT.
module square_wave_ctrl
  import wavegen_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DIV_W  = DIV_W_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [ACC_W-1:0]  i_cfg_ftw,
  input  logic [3:0]        i_cfg_sel,
  input  logic [DIV_W-1:0]  i_cfg_div,
  output logic [ADDR_W-1:0] o_addr,
  output logic [3:0]        o_sel,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_wrap,
  output logic              o_overrun,
  output logic              o_busy
);

  state_t state, state_nxt;
  cfg_t   act, shadow;
  logic   shadow_full, rst_done;
  logic   tick, load, carry, wrap_evt, xfer, apply, go_idle;
  logic [ADDR_W-1:0] addr_next;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // STOP lingers until the pending sample has been taken downstream.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_en) state_nxt = RUN;
      RUN:     if (!i_en) state_nxt = STOP;
      STOP:    if (i_en) state_nxt = RUN;
               else if (!o_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy      = (state != IDLE);
  assign go_idle     = (state == STOP) && (state_nxt == IDLE);
  assign o_cfg_ready = rst_done && !shadow_full;
  assign xfer        = i_cfg_valid && o_cfg_ready;
  assign load        = tick && (!o_valid || i_ready);
  assign wrap_evt    = load && carry;
  assign apply       = shadow_full && ((state == IDLE) || wrap_evt);

  wavegen_nco #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) u_nco (
    .clk       (i_clk),
    .rst       (i_rst),
    .run       (state == RUN),
    .load      (load),
    .clear     (go_idle),
    .ftw       (ACC_W'(act.ftw)),
    .div       (DIV_W'(act.div)),
    .tick      (tick),
    .addr_next (addr_next),
    .carry     (carry)
  );

  // While running, new settings land only at a period boundary so the duty never glitches.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      act         <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      rst_done    <= 1'b0;
    end else begin
      rst_done    <= 1'b1;
      shadow_full <= xfer || (shadow_full && !apply);
      if (apply) act <= shadow;
      if (xfer) begin
        shadow.ftw <= ftw_t'(i_cfg_ftw);
        shadow.sel <= clamp_sel(i_cfg_sel);
        shadow.div <= div_t'(i_cfg_div);
      end
    end
  end

  // The wrap sample still carries the old duty because act updates on the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_addr    <= '0;
      o_sel     <= '0;
      o_valid   <= 1'b0;
      o_wrap    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_wrap    <= wrap_evt;
      o_overrun <= tick && o_valid && !i_ready;
      if (load) begin
        o_valid <= 1'b1;
        o_addr  <= addr_next;
        o_sel   <= act.sel;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_square_wave_ctrl.sv
// Scoreboard bench for square_wave_ctrl: a phase-accumulator model pushes expected
// samples, each accepted sample is popped and compared.
module tb_square_wave_ctrl;

  localparam int ACC_W  = 24;
  localparam int ADDR_W = 10;
  localparam int DIV_W  = 16;

  logic              i_clk = 1'b0;
  logic              i_rst, i_en, i_cfg_valid, i_ready;
  logic              o_cfg_ready, o_valid, o_wrap, o_overrun, o_busy;
  logic [ACC_W-1:0]  i_cfg_ftw;
  logic [3:0]        i_cfg_sel, o_sel;
  logic [DIV_W-1:0]  i_cfg_div;
  logic [ADDR_W-1:0] o_addr;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        sel;
    logic              wrap;
  } exp_t;

  exp_t             sbq[$];
  logic [ACC_W-1:0] model_acc;
  int               checks   = 0;
  int               failures = 0;

  always #5 i_clk = ~i_clk;

  square_wave_ctrl #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_cfg_ftw   (i_cfg_ftw),
    .i_cfg_sel   (i_cfg_sel),
    .i_cfg_div   (i_cfg_div),
    .o_addr      (o_addr),
    .o_sel       (o_sel),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_wrap      (o_wrap),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  // Reference accumulator: one call per sample the DUT is expected to emit.
  task automatic model_push(input logic [ACC_W-1:0] ftw, input logic [3:0] sel);
    logic [ACC_W:0] s;
    exp_t e;
    s = {1'b0, model_acc} + {1'b0, ftw};
    model_acc = s[ACC_W-1:0];
    e.addr = model_acc[ACC_W-1 -: ADDR_W];
    e.sel  = sel;
    e.wrap = s[ACC_W];
    sbq.push_back(e);
  endtask

  task automatic cfg_write(input logic [ACC_W-1:0] ftw, input logic [3:0] sel,
                           input logic [DIV_W-1:0] div, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge i_clk);
      if (o_cfg_ready) ok = 1'b1;
    end
    if (ok) begin
      i_cfg_ftw = ftw; i_cfg_sel = sel; i_cfg_div = div; i_cfg_valid = 1'b1;
      @(negedge i_clk);
      i_cfg_valid = 1'b0;
      @(negedge i_clk);
    end
  endtask

  task automatic go_idle(output bit ok);
    ok = 1'b0;
    i_en = 1'b0; i_ready = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge i_clk);
      if (!o_busy) ok = 1'b1;
    end
    sbq.delete();
    model_acc = '0;
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    checks++;
    if ({o_valid, o_addr, o_sel, o_wrap, o_overrun, o_busy, o_cfg_ready} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got valid=%b addr=%0d sel=%0d wrap=%b ovr=%b busy=%b rdy=%b, expected all 0",
               o_valid, o_addr, o_sel, o_wrap, o_overrun, o_busy, o_cfg_ready);
    end
    i_rst = 1'b0;
    #1;
    checks++;
    if (o_cfg_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_ready_low: got %b expected 0", o_cfg_ready);
    end
    @(negedge i_clk);
    checks++;
    if (o_cfg_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_ready_rise: got %b expected 1", o_cfg_ready);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int got = 0, first_cyc = -1, last_cyc = -1;
    exp_t e;
    model_acc = '0;
    cfg_write(24'h004000, 4'd5, 16'd0, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL basic_cfg: got no ready expected ready"); end
    for (int i = 0; i < 1030; i++) model_push(24'h004000, 4'd5);
    i_ready = 1'b1; i_en = 1'b1;
    for (int cyc = 0; cyc < 1100 && got < 1030; cyc++) begin
      @(negedge i_clk);
      if (o_valid && i_ready) begin
        e = sbq.pop_front(); got++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        checks++;
        if (o_addr !== e.addr || o_sel !== e.sel || o_wrap !== e.wrap) begin
          failures++;
          $display("[TB] FAIL basic_sample%0d: got addr=%0d sel=%0d wrap=%b expected addr=%0d sel=%0d wrap=%b",
                   got, o_addr, o_sel, o_wrap, e.addr, e.sel, e.wrap);
        end
      end
    end
    checks++;
    if (got != 1030 || (last_cyc - first_cyc) != 1029) begin
      failures++;
      $display("[TB] FAIL basic_rate: got %0d samples over %0d clocks expected 1030 over 1029",
               got, last_cyc - first_cyc);
    end
    go_idle(ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL basic_idle: got busy expected idle"); end
  endtask

  task automatic test_div();
    bit ok;
    int got = 0, prev_cyc = -1;
    exp_t e;
    model_acc = '0;
    cfg_write(24'h008000, 4'd12, 16'd3, ok);
    for (int i = 0; i < 8; i++) model_push(24'h008000, 4'd0);
    i_ready = 1'b1; i_en = 1'b1;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      @(negedge i_clk);
      if (o_valid && i_ready) begin
        e = sbq.pop_front(); got++;
        checks++;
        if (o_addr !== e.addr || o_sel !== e.sel) begin
          failures++;
          $display("[TB] FAIL div_sample%0d: got addr=%0d sel=%0d expected addr=%0d sel=%0d",
                   got, o_addr, o_sel, e.addr, e.sel);
        end
        if (prev_cyc >= 0) begin
          checks++;
          if (cyc - prev_cyc != 4) begin
            failures++; $display("[TB] FAIL div_gap%0d: got %0d clocks expected 4", got, cyc - prev_cyc);
          end
        end
        prev_cyc = cyc;
      end
    end
    checks++;
    if (got != 8) begin failures++; $display("[TB] FAIL div_count: got %0d expected 8", got); end
    go_idle(ok);
  endtask

  task automatic test_overrun();
    bit ok;
    int got = 0, held = 0, ovr_seen = 0;
    exp_t e;
    model_acc = '0;
    cfg_write(24'h004000, 4'd5, 16'd0, ok);
    for (int i = 0; i < 12; i++) model_push(24'h004000, 4'd5);
    i_ready = 1'b1; i_en = 1'b1;
    for (int cyc = 0; cyc < 100 && got < 12; cyc++) begin
      @(negedge i_clk);
      if (o_overrun === 1'b1) ovr_seen++;
      if (got == 5 && held < 10) begin
        i_ready = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o_addr !== sbq[0].addr || o_overrun !== (held != 0)) begin
          failures++;
          $display("[TB] FAIL overrun_hold%0d: got valid=%b addr=%0d ovr=%b expected valid=1 addr=%0d ovr=%b",
                   held, o_valid, o_addr, o_overrun, sbq[0].addr, held != 0);
        end
        held++;
      end else begin
        i_ready = 1'b1;
        if (o_valid) begin
          e = sbq.pop_front(); got++;
          checks++;
          if (o_addr !== e.addr) begin
            failures++; $display("[TB] FAIL overrun_sample%0d: got addr=%0d expected %0d", got, o_addr, e.addr);
          end
        end
      end
    end
    checks++;
    if (ovr_seen != 10 || got != 12) begin
      failures++;
      $display("[TB] FAIL overrun_count: got %0d pulses %0d samples expected 10 pulses 12 samples", ovr_seen, got);
    end
    go_idle(ok);
  endtask

  task automatic test_cfg_mid();
    bit ok;
    int got = 0, phase = 0, blocked = 0;
    logic exp_rdy;
    exp_t e;
    model_acc = '0;
    cfg_write(24'h100000, 4'd5, 16'd0, ok);
    for (int i = 1; i <= 40; i++)
      model_push(24'h100000, (i <= 16) ? 4'd5 : (i <= 32) ? 4'd2 : 4'd9);
    i_ready = 1'b1; i_en = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 40; cyc++) begin
      @(negedge i_clk);
      case (phase)
        0: if (got == 5) begin
             i_cfg_ftw = 24'h100000; i_cfg_sel = 4'd2; i_cfg_div = 16'd0; i_cfg_valid = 1'b1;
             phase = 1;
           end
        1: begin
             checks++;
             if (o_cfg_ready !== 1'b0) begin
               failures++; $display("[TB] FAIL cfg_full: got ready=%b expected 0", o_cfg_ready);
             end
             i_cfg_sel = 4'd9;
             phase = 2;
           end
        2: begin
             exp_rdy = sbq[0].wrap;
             checks++;
             if (o_cfg_ready !== exp_rdy) begin
               failures++; $display("[TB] FAIL cfg_blocked: got ready=%b expected %b", o_cfg_ready, exp_rdy);
             end
             if (!exp_rdy) blocked++;
             if (o_cfg_ready) phase = 3;
           end
        3: begin i_cfg_valid = 1'b0; phase = 4; end
        default: ;
      endcase
      if (o_valid && i_ready) begin
        e = sbq.pop_front(); got++;
        checks++;
        if (o_addr !== e.addr || o_sel !== e.sel || o_wrap !== e.wrap) begin
          failures++;
          $display("[TB] FAIL cfg_sample%0d: got addr=%0d sel=%0d wrap=%b expected addr=%0d sel=%0d wrap=%b",
                   got, o_addr, o_sel, o_wrap, e.addr, e.sel, e.wrap);
        end
      end
    end
    i_cfg_valid = 1'b0;
    checks++;
    if (blocked != 8 || got != 40) begin
      failures++; $display("[TB] FAIL cfg_block_len: got %0d blocked %0d samples expected 8 and 40", blocked, got);
    end
    go_idle(ok);
  endtask

  task automatic test_stop();
    bit ok, seen;
    exp_t e;
    model_acc = '0;
    cfg_write(24'h024000, 4'd3, 16'd3, ok);
    model_push(24'h024000, 4'd3);
    i_ready = 1'b0; i_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge i_clk);
      if (o_valid) seen = 1'b1;
    end
    i_en = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (!seen || o_addr !== e.addr || o_sel !== e.sel) begin
      failures++;
      $display("[TB] FAIL stop_first: got valid=%b addr=%0d sel=%0d expected valid=1 addr=%0d sel=%0d",
               seen, o_addr, o_sel, e.addr, e.sel);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      checks++;
      if (o_busy !== 1'b1 || o_valid !== 1'b1 || o_addr !== e.addr) begin
        failures++;
        $display("[TB] FAIL stop_hold%0d: got busy=%b valid=%b addr=%0d expected busy=1 valid=1 addr=%0d",
                 i, o_busy, o_valid, o_addr, e.addr);
      end
    end
    @(negedge i_clk);
    i_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge i_clk);
      if (!o_busy) seen = 1'b1;
    end
    checks++;
    if (!seen || o_valid !== 1'b0 || o_addr !== e.addr) begin
      failures++;
      $display("[TB] FAIL stop_idle: got idle=%b valid=%b addr=%0d expected idle=1 valid=0 addr=%0d",
               seen, o_valid, o_addr, e.addr);
    end
    model_acc = '0;
    model_push(24'h024000, 4'd3);
    i_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge i_clk);
      if (o_valid) seen = 1'b1;
    end
    e = sbq.pop_front();
    checks++;
    if (!seen || o_addr !== e.addr) begin
      failures++; $display("[TB] FAIL stop_restart: got valid=%b addr=%0d expected valid=1 addr=%0d", seen, o_addr, e.addr);
    end
    go_idle(ok);
  endtask

  task automatic test_async_reset();
    bit ok;
    cfg_write(24'h004000, 4'd7, 16'd0, ok);
    i_ready = 1'b1; i_en = 1'b1;
    repeat (20) @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b1 || o_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL arst_pre: got busy=%b valid=%b expected 1 1", o_busy, o_valid);
    end
    #2 i_rst = 1'b1;
    #1;
    checks++;
    if ({o_valid, o_addr, o_sel, o_wrap, o_overrun, o_busy, o_cfg_ready} !== '0) begin
      failures++;
      $display("[TB] FAIL arst_outputs: got valid=%b addr=%0d sel=%0d wrap=%b ovr=%b busy=%b rdy=%b, expected all 0",
               o_valid, o_addr, o_sel, o_wrap, o_overrun, o_busy, o_cfg_ready);
    end
    i_en = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_cfg_ready !== 1'b1 || o_busy !== 1'b0) begin
      failures++; $display("[TB] FAIL arst_release: got rdy=%b busy=%b expected 1 0", o_cfg_ready, o_busy);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b0; i_cfg_valid = 1'b0; i_ready = 1'b1;
    i_cfg_ftw = '0; i_cfg_sel = '0; i_cfg_div = '0; model_acc = '0;
    test_reset();
    test_basic();
    test_div();
    test_overrun();
    test_cfg_mid();
    test_stop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
